// File: rtl/display_serializer_pkg.sv
// Shared types and segment lookup for the serial 7-segment display block.
package display_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CONVERT = 3'd1,
        LOAD    = 3'd2,
        SHIFT   = 3'd3,
        DONE    = 3'd4
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Active-high segment pattern, bit order gfedcba.
    function automatic logic [6:0] seg_encode(input logic [3:0] nib);
        logic [6:0] code;
        case (nib)
            4'h0: code = 7'h3F;
            4'h1: code = 7'h06;
            4'h2: code = 7'h5B;
            4'h3: code = 7'h4F;
            4'h4: code = 7'h66;
            4'h5: code = 7'h6D;
            4'h6: code = 7'h7D;
            4'h7: code = 7'h07;
            4'h8: code = 7'h7F;
            4'h9: code = 7'h6F;
            4'hA: code = 7'h77;
            4'hB: code = 7'h7C;
            4'hC: code = 7'h39;
            4'hD: code = 7'h5E;
            4'hE: code = 7'h79;
            default: code = 7'h71;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/display_serializer_if.sv
// Request and LED-chain signals of the display serializer.
interface display_serializer_if #(
    parameter int NUM_DIGITS = 4,
    parameter int DATA_W     = 16
);
    logic                            start;
    logic [DATA_W-1:0]               data;
    logic [$clog2(NUM_DIGITS+1)-1:0] digit_count;
    logic                            hex_mode;
    logic [NUM_DIGITS-1:0]           dp_mask;
    logic                            next_led;
    logic                            led_data;
    logic                            led_valid;
    logic                            busy;
    logic                            done;

    modport master (
        output start, data, digit_count, hex_mode, dp_mask, next_led,
        input  led_data, led_valid, busy, done
    );

    modport slave (
        input  start, data, digit_count, hex_mode, dp_mask, next_led,
        output led_data, led_valid, busy, done
    );
endinterface

// File: rtl/display_serializer_bin2bcd_iter.sv
// Sequential double-dabble: one add-3/shift step per cycle for DATA_W cycles.
module bin2bcd_iter #(
    parameter int DATA_W     = 16,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [DATA_W-1:0]       bin,
    output logic [NUM_DIGITS*4-1:0] bcd,
    output logic                    done
);
    localparam int BCD_W = NUM_DIGITS * 4;
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] bin_sr;
    logic [CNT_W-1:0]  cnt;
    logic [BCD_W-1:0]  adj;

    always_comb begin
        adj = bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // High during the cycle whose step is the last one.
    assign done = (cnt == CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd    <= '0;
            bin_sr <= '0;
            cnt    <= '0;
        end else if (start) begin
            bcd    <= '0;
            bin_sr <= bin;
            cnt    <= CNT_W'(DATA_W);
        end else if (cnt != '0) begin
            // The top BCD bit is dropped: values wider than the register wrap.
            bcd    <= {adj[BCD_W-2:0], bin_sr[DATA_W-1]};
            bin_sr <= {bin_sr[DATA_W-2:0], 1'b0};
            cnt    <= cnt - CNT_W'(1);
        end
    end
endmodule

// File: rtl/display_serializer.sv
// Binary to 7-segment serializer with start/done handshake.
// Optional leading-zero blanking with `define DISPLAY_SERIALIZER_LZB_EN.
module display_serializer
    import display_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DATA_W     = 16,
    parameter int SEG_W      = 8
) (
    input logic                 clk,
    input logic                 rst,
    display_serializer_if.slave bus
);
    localparam int DC_W  = $clog2(NUM_DIGITS + 1);
    localparam int SR_W  = NUM_DIGITS * SEG_W;
    localparam int BC_W  = $clog2(SR_W + 1);
    localparam int NIB_W = NUM_DIGITS * 4;

    localparam logic [2:0] ST_IDLE    = 3'(IDLE);
    localparam logic [2:0] ST_CONVERT = 3'(CONVERT);
    localparam logic [2:0] ST_LOAD    = 3'(LOAD);
    localparam logic [2:0] ST_SHIFT   = 3'(SHIFT);
    localparam logic [2:0] ST_DONE    = 3'(DONE);

    logic [2:0]            state;
    logic [DATA_W-1:0]     data_lat;
    logic [DC_W-1:0]       dc_lat;
    logic                  hex_lat;
    logic [NUM_DIGITS-1:0] dp_lat;
    logic [SR_W-1:0]       sr;
    logic [SR_W-1:0]       sr_load;
    logic [BC_W-1:0]       bits_left;
    logic [NIB_W-1:0]      bcd;
    logic [NIB_W-1:0]      nibs;
    logic [6:0]            seg;
    logic [DC_W-1:0]       dc_clamped;
    logic                  conv_start;
    logic                  conv_done;
`ifdef DISPLAY_SERIALIZER_LZB_EN
    logic                  nz_seen;
`endif

    assign dc_clamped = (bus.digit_count > DC_W'(NUM_DIGITS)) ? DC_W'(NUM_DIGITS)
                                                              : bus.digit_count;
    assign conv_start = (state == ST_IDLE) && bus.start && !bus.hex_mode;

    bin2bcd_iter #(
        .DATA_W     (DATA_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bin   (bus.data),
        .bcd   (bcd),
        .done  (conv_done)
    );

    // Hex digits past the top of data read as zero through the size cast.
    assign nibs = hex_lat ? NIB_W'(data_lat) : bcd;

    always_comb begin
        sr_load = '0;
        seg     = SEG_BLANK;
`ifdef DISPLAY_SERIALIZER_LZB_EN
        nz_seen = 1'b0;
`endif
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            seg = seg_encode(nibs[4*i +: 4]);
`ifdef DISPLAY_SERIALIZER_LZB_EN
            // Scan from the top; only digits actually emitted can stop blanking.
            if (DC_W'(i) < dc_lat && nibs[4*i +: 4] != 4'd0)
                nz_seen = 1'b1;
            if (!nz_seen && i != 0)
                seg = SEG_BLANK;
`endif
            sr_load[i*SEG_W +: SEG_W] = SEG_W'({dp_lat[i], seg});
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            data_lat  <= '0;
            dc_lat    <= '0;
            hex_lat   <= 1'b0;
            dp_lat    <= '0;
            sr        <= '0;
            bits_left <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        data_lat <= bus.data;
                        dc_lat   <= dc_clamped;
                        hex_lat  <= bus.hex_mode;
                        dp_lat   <= bus.dp_mask;
                        state    <= bus.hex_mode ? ST_LOAD : ST_CONVERT;
                    end
                end
                ST_CONVERT: begin
                    if (conv_done)
                        state <= ST_LOAD;
                end
                ST_LOAD: begin
                    sr        <= sr_load;
                    bits_left <= BC_W'(dc_lat) * BC_W'(SEG_W);
                    state     <= (dc_lat == '0) ? ST_DONE : ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (bus.next_led) begin
                        sr        <= sr >> 1;
                        bits_left <= bits_left - BC_W'(1);
                        if (bits_left == BC_W'(1))
                            state <= ST_DONE;
                    end
                end
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    assign bus.led_valid = (state == ST_SHIFT);
    assign bus.led_data  = (state == ST_SHIFT) && sr[0];
    assign bus.busy      = (state == ST_CONVERT) || (state == ST_LOAD) || (state == ST_SHIFT);
    assign bus.done      = (state == ST_DONE);
endmodule

// File: tb/tb_display_serializer.sv
// Randomized bench for display_serializer against an arithmetic reference model.
module tb_display_serializer;
    localparam int NUM_DIGITS = 4;
    localparam int DATA_W     = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [7:0] seg_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                 8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    display_serializer_if #(.NUM_DIGITS(NUM_DIGITS), .DATA_W(DATA_W)) bus ();

    display_serializer #(.NUM_DIGITS(NUM_DIGITS), .DATA_W(DATA_W), .SEG_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned model_digit(int unsigned d, bit hx, int i);
        int unsigned modv = 1;
        int unsigned p    = 1;
        if (hx)
            return (4 * i < DATA_W) ? ((d >> (4 * i)) & 15) : 0;
        for (int k = 0; k < NUM_DIGITS; k++) modv *= 10;
        for (int k = 0; k < i; k++) p *= 10;
        return ((d % modv) / p) % 10;
    endfunction

    task automatic run_txn(input int unsigned d, input int dc, input bit hx,
                           input logic [NUM_DIGITS-1:0] dp, input bit noise);
        int         dce;
        int         top;
        int         lat;
        int         n;
        int         total;
        int         st;
        bit         vld_ok;
        logic [7:0] cur;
        logic [7:0] exp_b [NUM_DIGITS];

        dce = (dc > NUM_DIGITS) ? NUM_DIGITS : dc;
        top = 0;
        for (int i = 0; i < dce; i++)
            if (model_digit(d, hx, i) != 0) top = i;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            exp_b[i] = seg_tab[model_digit(d, hx, i)];
`ifdef DISPLAY_SERIALIZER_LZB_EN
            if (i > top) exp_b[i] = 8'h00;
`endif
            exp_b[i][7] = dp[i];
        end
        lat = hx ? 2 : DATA_W + 2;

        @(negedge clk);
        bus.start       = 1'b1;
        bus.data        = d[DATA_W-1:0];
        bus.digit_count = 3'(dc);
        bus.hex_mode    = hx;
        bus.dp_mask     = dp;
        @(negedge clk);
        bus.start = 1'b0;
        n = 1;
        while (!(bus.led_valid || bus.done) && n < 100) begin
            if (noise) begin
                bus.start       = 1'($urandom_range(0, 1));
                bus.next_led    = 1'($urandom_range(0, 1));
                bus.data        = DATA_W'($urandom);
                bus.hex_mode    = 1'($urandom_range(0, 1));
                bus.digit_count = 3'($urandom_range(0, 7));
            end
            @(negedge clk);
            n++;
        end
        bus.start    = 1'b0;
        bus.next_led = 1'b0;
        chk("latency", n, lat);

        if (dce == 0) begin
            chk("done_no_digits", {bus.done, bus.led_valid, bus.busy}, 3'b100);
        end else begin
            total  = dce * 8;
            vld_ok = 1'b1;
            cur    = '0;
            for (int j = 0; j < total; j++) begin
                st = $urandom_range(0, 2);
                for (int s = 0; s <= st; s++) begin
                    if (!bus.led_valid || !bus.busy || bus.done) vld_ok = 1'b0;
                    cur[j % 8]   = bus.led_data;
                    bus.next_led = (s == st);
                    bus.start    = (noise && j < total - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                    @(negedge clk);
                end
                if (j % 8 == 7) chk($sformatf("byte%0d", j / 8), cur, exp_b[j / 8]);
            end
            bus.next_led = 1'b0;
            bus.start    = 1'b0;
            chk("valid_during_shift", vld_ok, 1);
            chk("done_pulse", {bus.done, bus.led_valid, bus.busy}, 3'b100);
        end
        @(negedge clk);
        chk("idle_after_done", {bus.done, bus.led_valid, bus.busy}, 3'b000);
    endtask

    initial begin
        int n;
        bus.start       = 1'b0;
        bus.data        = '0;
        bus.digit_count = '0;
        bus.hex_mode    = 1'b0;
        bus.dp_mask     = '0;
        bus.next_led    = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {bus.done, bus.led_valid, bus.busy, bus.led_data}, 4'b0000);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_outputs", {bus.done, bus.led_valid, bus.busy, bus.led_data}, 4'b0000);

        run_txn(25, 2, 1'b0, 4'b0000, 1'b0);
        run_txn(678, 3, 1'b0, 4'b0010, 1'b0);
        run_txn(32'h00AF, 4, 1'b1, 4'b0000, 1'b0);
        run_txn(1234, 2, 1'b0, 4'b0000, 1'b0);
        run_txn(1234, 0, 1'b1, 4'b0000, 1'b0);
        run_txn(0, 4, 1'b0, 4'b1001, 1'b0);
        run_txn(65535, 7, 1'b0, 4'b1111, 1'b0);

        // Abort mid-shift with reset, then a clean transaction.
        @(negedge clk);
        bus.start       = 1'b1;
        bus.data        = 16'd25;
        bus.digit_count = 3'd2;
        bus.hex_mode    = 1'b0;
        bus.dp_mask     = '0;
        @(negedge clk);
        bus.start = 1'b0;
        n = 1;
        while (!bus.led_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("abort_latency", n, DATA_W + 2);
        bus.next_led = 1'b1;
        repeat (5) @(negedge clk);
        bus.next_led = 1'b0;
        chk("abort_still_busy", {bus.led_valid, bus.busy}, 2'b11);
        rst = 1'b1;
        #1;
        chk("abort_outputs", {bus.done, bus.led_valid, bus.busy, bus.led_data}, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_no_done", {bus.done, bus.led_valid, bus.busy}, 3'b000);
        run_txn(9, 1, 1'b0, 4'b0000, 1'b0);

        run_txn(25, 2, 1'b0, 4'b0000, 1'b1);

        for (int t = 0; t < 40; t++)
            run_txn($urandom_range(0, 65535), $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
